// File: rtl/cnn_layer_accel_window_pooler.sv
// Streaming k x k (k=2/3) max/min window pooler over one raster-order channel.
// Two line buffers plus per-row tap registers feed a registered valid/ready output.
//
// state | meaning
// IDLE  | waiting for an opcode; illegal geometry is accepted but never leaves IDLE
// RUN   | consuming W*H pixels, emitting a result per completed window
// FLUSH | all pixels taken, waiting for the output register to drain
module cnn_layer_accel_window_pooler #(
   parameter int C_DATAIN_WIDTH  = 16,
   parameter int C_MAX_IMG_WIDTH = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [63:0]               opcode,
   input  logic                      opcode_valid,
   output logic                      opcode_accept,
   input  logic [C_DATAIN_WIDTH-1:0] datain,
   input  logic                      datain_valid,
   output logic                      datain_ready,
   output logic [C_DATAIN_WIDTH-1:0] dataout,
   output logic                      dataout_valid,
   input  logic                      dataout_ready,
   output logic                      dataout_last,
   output logic                      busy,
   output logic                      cfg_error
);
   localparam int DW = C_DATAIN_WIDTH;
   localparam int CW = (C_MAX_IMG_WIDTH > 1) ? $clog2(C_MAX_IMG_WIDTH) : 1;
   // taps 0,1 = current row (c, c-1), 3,4 = previous row (c, c-1)
   localparam logic [8:0] K2_TAPS = 9'b000011011;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [15:0]     cfg_w, cfg_h;
   logic            cfg_k3, cfg_s2, cfg_sgn, cfg_min;
   logic [15:0]     col, row;
   logic [DW-1:0]   lb0 [C_MAX_IMG_WIDTH];
   logic [DW-1:0]   lb1 [C_MAX_IMG_WIDTH];
   logic [DW-1:0]   win0 [2];
   logic [DW-1:0]   win1 [2];
   logic [DW-1:0]   win2 [2];
   logic [DW-1:0]   taps [9];
   logic [DW-1:0]   red;
   logic [CW-1:0]   col_idx;
   logic [15:0]     km1, w_span, h_span, last_c, last_r;
   logic            op_legal, xfer, row_ok, col_ok, win_done, win_last, frame_end;
   logic            unused_opcode_bits;

   assign unused_opcode_bits = &{1'b0, opcode[63:36]};

   function automatic logic wins(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic sgn, input logic mn);
      logic gt, lt;
      gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
      lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
      return mn ? lt : gt;
   endfunction

   assign op_legal = (opcode[15:0] != 16'd0) && (opcode[31:16] != 16'd0) &&
                     (opcode[15:0] <= 16'(C_MAX_IMG_WIDTH));
   assign xfer     = datain_valid & datain_ready;
   assign col_idx  = col[CW-1:0];
   assign km1      = cfg_k3 ? 16'd2 : 16'd1;

   // (r-(k-1)) is even exactly when r has the same parity as k-1
   assign row_ok   = (row >= km1) && (!cfg_s2 || (row[0] == ~cfg_k3));
   assign col_ok   = (col >= km1) && (!cfg_s2 || (col[0] == ~cfg_k3));
   assign win_done = xfer & row_ok & col_ok;

   assign w_span   = cfg_w - km1 - 16'd1;
   assign h_span   = cfg_h - km1 - 16'd1;
   assign last_c   = km1 + (cfg_s2 ? {w_span[15:1], 1'b0} : w_span);
   assign last_r   = km1 + (cfg_s2 ? {h_span[15:1], 1'b0} : h_span);
   assign win_last = (row == last_r) && (col == last_c);
   assign frame_end = xfer && (col == cfg_w - 16'd1) && (row == cfg_h - 16'd1);

   always_comb begin
      taps[0] = datain;
      taps[1] = win0[0];
      taps[2] = win0[1];
      taps[3] = lb0[col_idx];
      taps[4] = win1[0];
      taps[5] = win1[1];
      taps[6] = lb1[col_idx];
      taps[7] = win2[0];
      taps[8] = win2[1];
      red = datain;
      for (int i = 1; i < 9; i++) begin
         if ((cfg_k3 || K2_TAPS[i]) && wins(taps[i], red, cfg_sgn, cfg_min))
            red = taps[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (opcode_valid && op_legal) state_nxt = RUN;
         RUN:     if (frame_end) state_nxt = FLUSH;
         FLUSH:   if (!dataout_valid || dataout_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      opcode_accept = 1'b0;
      datain_ready  = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE:    opcode_accept = opcode_valid;
         RUN:     begin
                     datain_ready = !dataout_valid || dataout_ready;
                     busy         = 1'b1;
                  end
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_w         <= '0;
         cfg_h         <= '0;
         cfg_k3        <= 1'b0;
         cfg_s2        <= 1'b0;
         cfg_sgn       <= 1'b0;
         cfg_min       <= 1'b0;
         cfg_error     <= 1'b0;
         col           <= '0;
         row           <= '0;
         dataout       <= '0;
         dataout_valid <= 1'b0;
         dataout_last  <= 1'b0;
      end else begin
         if (opcode_accept) begin
            cfg_w     <= opcode[15:0];
            cfg_h     <= opcode[31:16];
            cfg_k3    <= opcode[32];
            cfg_s2    <= opcode[33];
            cfg_sgn   <= opcode[34];
            cfg_min   <= opcode[35];
            cfg_error <= !op_legal;
            col       <= '0;
            row       <= '0;
         end else if (xfer) begin
            if (col == cfg_w - 16'd1) begin
               col <= '0;
               row <= row + 16'd1;
            end else begin
               col <= col + 16'd1;
            end
         end
         if (win_done) begin
            dataout       <= red;
            dataout_valid <= 1'b1;
            dataout_last  <= win_last;
         end else if (dataout_ready) begin
            dataout_valid <= 1'b0;
            dataout_last  <= 1'b0;
         end
      end
   end

   // Rows above k-1 never reach a window, so stale buffer contents are harmless.
   always_ff @(posedge clk) begin
      if (xfer) begin
         lb0[col_idx] <= datain;
         lb1[col_idx] <= lb0[col_idx];
         win0[1]      <= win0[0];
         win0[0]      <= datain;
         win1[1]      <= win1[0];
         win1[0]      <= lb0[col_idx];
         win2[1]      <= win2[0];
         win2[0]      <= lb1[col_idx];
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_window_pooler.sv
// Directed bench for the window pooler: a window-level software model feeds an
// expected-result queue that one negedge process checks every output handshake against.
module tb_cnn_layer_accel_window_pooler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] opcode = '0;
   logic        opcode_valid = 1'b0;
   logic        opcode_accept;
   logic [15:0] datain = '0;
   logic        datain_valid = 1'b0;
   logic        datain_ready;
   logic [15:0] dataout;
   logic        dataout_valid;
   logic        dataout_ready = 1'b1;
   logic        dataout_last;
   logic        busy;
   logic        cfg_error;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_results = 0;
   bit          ready_rand = 1'b0;
   logic [16:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [15:0] t1_q[$];
   logic [15:0] img [0:9][0:9];
   logic [15:0] img_t1 [0:9][0:9];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_last = 1'b0;

   cnn_layer_accel_window_pooler #(.C_DATAIN_WIDTH(16), .C_MAX_IMG_WIDTH(128)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
      .opcode_accept(opcode_accept), .datain(datain), .datain_valid(datain_valid),
      .datain_ready(datain_ready), .dataout(dataout), .dataout_valid(dataout_valid),
      .dataout_ready(dataout_ready), .dataout_last(dataout_last), .busy(busy),
      .cfg_error(cfg_error));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk_op(input int w, input int h, input bit k3,
                                         input bit s2, input bit sg, input bit mn);
      logic [63:0] op;
      op = '0;
      op[15:0]  = w[15:0];
      op[31:16] = h[15:0];
      op[32]    = k3;
      op[33]    = s2;
      op[34]    = sg;
      op[35]    = mn;
      return op;
   endfunction

   function automatic int as_int(input logic [15:0] v, input bit sg);
      return sg ? int'($signed(v)) : int'(v);
   endfunction

   // Window-by-window reference: top-left corners stepped by S, raster order.
   task automatic build_exp(input int w, input int h, input int k, input int s,
                            input bit sg, input bit mn);
      logic [15:0] best;
      logic [15:0] v;
      exp_q.delete();
      if (w >= k && h >= k) begin
         for (int r0 = 0; r0 + k <= h; r0 += s)
            for (int c0 = 0; c0 + k <= w; c0 += s) begin
               best = img[r0][c0];
               for (int i = 0; i < k; i++)
                  for (int j = 0; j < k; j++) begin
                     v = img[r0+i][c0+j];
                     if (mn ? (as_int(v, sg) < as_int(best, sg)) : (as_int(v, sg) > as_int(best, sg)))
                        best = v;
                  end
               exp_q.push_back({1'b0, best});
            end
         exp_q[exp_q.size()-1][16] = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (ready_rand) dataout_ready = 1'($urandom_range(0, 1));
      else            dataout_ready = 1'b1;
   end

   always @(negedge clk) begin
      logic [16:0] e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (dataout_valid && !dataout_ready) chk("stall blocks input", datain_ready, 0);
         if (prev_stall) begin
            chk("stall valid held", dataout_valid, 1);
            chk("stall data stable", dataout, prev_data);
            chk("stall last stable", dataout_last, prev_last);
         end
         if (dataout_valid && dataout_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("result data", dataout, e[15:0]);
               chk("result last", dataout_last, e[16]);
            end
            got_q.push_back(dataout);
            n_results++;
         end
         prev_stall = dataout_valid && !dataout_ready;
         prev_data  = dataout;
         prev_last  = dataout_last;
      end
   end

   task automatic chk_reset_vals();
      chk("rst opcode_accept", opcode_accept, 0);
      chk("rst datain_ready", datain_ready, 0);
      chk("rst dataout_valid", dataout_valid, 0);
      chk("rst dataout_last", dataout_last, 0);
      chk("rst busy", busy, 0);
      chk("rst cfg_error", cfg_error, 0);
      chk("rst dataout", dataout, 0);
   endtask

   task automatic start_op(input logic [63:0] op);
      int n = 0;
      opcode = op;
      opcode_valid = 1'b1;
      @(negedge clk);
      while (!opcode_accept && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("opcode_accept", opcode_accept, 1);
      @(posedge clk);
      #1;
      opcode_valid = 1'b0;
   endtask

   task automatic send_pixels(input int w, input int h, input int npix, input bit gaps);
      int cnt = 0;
      int n;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            if (cnt < npix) begin
               if (gaps && $urandom_range(0, 2) == 0) begin
                  datain_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               datain = img[r][c];
               datain_valid = 1'b1;
               n = 0;
               @(negedge clk);
               while (!datain_ready && n < 500) begin
                  @(negedge clk);
                  n++;
               end
               if (!datain_ready) chk("datain_ready timeout", 0, 1);
               @(posedge clk);
               #1;
               cnt++;
            end
         end
      datain_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("frame completes", busy, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int w, input int h, input bit k3, input bit s2,
                            input bit sg, input bit mn, input bit gaps, input int exp_cnt);
      n_results = 0;
      got_q.delete();
      build_exp(w, h, k3 ? 3 : 2, s2 ? 2 : 1, sg, mn);
      chk("model result count", exp_q.size(), exp_cnt);
      start_op(mk_op(w, h, k3, s2, sg, mn));
      @(negedge clk);
      chk("busy after accept", busy, 1);
      chk("cfg_error legal", cfg_error, 0);
      @(posedge clk);
      #1;
      send_pixels(w, h, w * h, gaps);
      wait_idle();
      chk("result count", n_results, exp_cnt);
      chk("queue drained", exp_q.size(), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals();
      @(posedge clk);
      #1;

      // 10x10 random, 3x3 stride 1 max
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) begin
            img[r][c]    = 16'($urandom_range(0, 100));
            img_t1[r][c] = img[r][c];
         end
      run_frame(10, 10, 1, 0, 0, 0, 0, 64);
      t1_q = got_q;

      // 8x8 ramp, 2x2 stride 2 max
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = 16'(r * 8 + c);
      build_exp(8, 8, 2, 2, 0, 0);
      chk("model ramp first", exp_q[0][15:0], 9);
      chk("model ramp last", exp_q[exp_q.size()-1][15:0], 63);
      run_frame(8, 8, 0, 1, 0, 0, 0, 16);
      chk("ramp first result", got_q[0], 9);
      chk("ramp last result", got_q[got_q.size()-1], 63);

      // 6x6 signed min, alternating extremes
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) img[r][c] = ((r * 6 + c) % 2 == 0) ? 16'h7FFF : 16'h8000;
      build_exp(6, 6, 3, 1, 1, 1);
      chk("model signed min", exp_q[0][15:0], 16'h8000);
      run_frame(6, 6, 1, 0, 1, 1, 0, 16);
      foreach (got_q[i]) chk("signed min result", got_q[i], 16'h8000);

      // same 10x10 image with random output stalls and input gaps
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) img[r][c] = img_t1[r][c];
      ready_rand = 1'b1;
      run_frame(10, 10, 1, 0, 0, 0, 1, 64);
      ready_rand = 1'b0;
      chk("stalled run count", got_q.size(), t1_q.size());
      for (int i = 0; i < got_q.size() && i < t1_q.size(); i++)
         chk("stalled vs unstalled", got_q[i], t1_q[i]);

      // illegal W=0 then legal 4x4 k=2
      begin
         int acc = 0;
         start_op(mk_op(0, 4, 0, 0, 0, 0));
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (opcode_accept) acc++;
            chk("illegal cfg_error", cfg_error, 1);
            chk("illegal busy", busy, 0);
            chk("illegal datain_ready", datain_ready, 0);
         end
         chk("illegal extra accepts", acc, 0);
         @(posedge clk);
         #1;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) img[r][c] = 16'(3 * r + 5 * c);
      run_frame(4, 4, 0, 0, 0, 0, 0, 9);

      // reset after 37 pixels of a 10x10 frame
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) img[r][c] = 16'($urandom_range(0, 1000));
      build_exp(10, 10, 3, 1, 0, 0);
      start_op(mk_op(10, 10, 1, 0, 0, 0));
      send_pixels(10, 10, 37, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk_reset_vals();
      @(posedge clk);
      #1;
      run_frame(10, 10, 1, 0, 0, 0, 0, 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
